uart_wrapper: RTL and testbench
===============================

UART_WRAPPER -- requirements
Module: uart_wrapper

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clk cycles per UART bit (50 MHz / 19200 baud).
REQ-002 SHALL have parameter GAP_TMO, default 2^20, meaning the maximum idle clk cycles allowed between bytes of one frame.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX  input  1  serial line from the BLE module, 8N1, idle high, asynchronous to clk.
REQ-006 SHALL have port clr_cmd_rdy  input  1  downstream consumer has digested the command.
REQ-007 SHALL have port cmd_rdy  output  1  a complete 24-bit command is held on cmd/data.
REQ-008 SHALL have port cmd  output  8  opcode byte of the latest complete frame.
REQ-009 SHALL have port data  output  16  parameter of the latest complete frame.

Function
REQ-010 SHALL double-flop RX into the clk domain before any use.
REQ-011 SHALL detect a start bit on a synchronized 1->0 transition while the receiver is idle.
REQ-012 SHALL sample each bit at BAUD_DIV/2 cycles into the bit; start, 8 data bits (LSB first), stop.
REQ-013 SHALL produce a one-cycle byte-valid pulse at the stop-bit sample when the stop bit is 1.
REQ-014 SHALL discard a byte whose stop bit is 0 (framing error), pulse nothing, and reset frame assembly to WAIT_CMD.
REQ-015 SHALL treat a start bit that reads 1 at its mid-sample as a glitch and return to idle.
REQ-016 SHALL assemble frames as byte0 = cmd, byte1 = data[7:0], byte2 = data[15:8].
REQ-017 SHALL use an assembly FSM with states WAIT_CMD, WAIT_LO and WAIT_HI; each valid byte advances WAIT_CMD->WAIT_LO->WAIT_HI->WAIT_CMD.
REQ-018 SHALL hold partial bytes in shadow registers; cmd/data SHALL update only in the cycle after the byte2 pulse, simultaneously with cmd_rdy rising.
REQ-019 SHALL hold cmd/data stable while cmd_rdy is 1, including while a new frame is being received.
REQ-020 SHALL clear cmd_rdy the cycle after clr_cmd_rdy=1.
REQ-021 SHALL also clear cmd_rdy on the byte-valid pulse of a new byte0, so a stale command is never presented alongside a new frame.
REQ-022 SHALL let set win when frame completion and clr_cmd_rdy occur in the same cycle: cmd_rdy=1.
REQ-023 SHALL ignore clr_cmd_rdy when cmd_rdy=0, with no side effect.
REQ-024 SHALL run a gap counter in WAIT_LO/WAIT_HI that is cleared on each valid byte; reaching GAP_TMO SHALL return the FSM to WAIT_CMD and drop the partial frame.
REQ-025 SHALL hold the gap counter at 0 in WAIT_CMD, with no wrap-around.
REQ-026 SHALL be latency-bound: cmd_rdy rises 1 cycle after the byte2 stop-bit sample.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-byte or mid-frame, force cmd_rdy=0, cmd=8'h00, data=16'h0000, FSM=WAIT_CMD, receiver idle, and all counters to 0.
REQ-028 SHALL preset the RX synchronizer flops to 1 so that reset release does not fake a start bit.

Structure
REQ-029 SHALL place the frame-FSM state enum and the byte-index constants in the shared package cmd_pkg.
REQ-030 SHALL implement the serial receiver as sub-module uart_rx (clk, rst_n, RX, rdy, rx_data, frm_err); uart_wrapper SHALL instantiate it once.
REQ-031 SHALL keep BAUD_DIV overridable, with benches using BAUD_DIV=16 and GAP_TMO=512 for fast simulation.

Verification
REQ-032 SHALL cover: send 0x02, 0x34, 0x12 -> cmd_rdy=1, cmd=8'h02, data=16'h1234; assert clr_cmd_rdy -> cmd_rdy=0 the next cycle.
REQ-033 SHALL cover: send 0x05, 0xFF, 0x01 without clr, then 0x03 -> cmd_rdy falls at the 0x03 byte; cmd/data stay 0x05/0x01FF until 0x03, 0x00, 0x80 completes -> cmd=8'h03, data=16'h8000.
REQ-034 SHALL cover: send 0x02, 0x10, then idle >512 cycles, then send 0x04, 0x20, 0x00 -> a single frame with cmd=8'h04, data=16'h0020.
REQ-035 SHALL cover: byte1 sent with stop bit forced 0 -> no cmd_rdy; the next three good bytes 0x06, 0x00, 0x00 -> cmd=8'h06.
REQ-036 SHALL cover: clr_cmd_rdy held high through the byte2 completion cycle -> cmd_rdy=1 after that cycle (set wins).
REQ-037 SHALL cover: rst_n pulsed low mid-byte1 -> all outputs 0, FSM=WAIT_CMD; a following full frame 0x08, 0x00, 0x00 is received correctly.

Source files
------------

// File: rtl/cmd_pkg.sv
// Command-frame shared definitions.
// Byte positions within a frame and the frame-assembly FSM state type.
package cmd_pkg;

  localparam logic [1:0] IDX_CMD = 2'd0;
  localparam logic [1:0] IDX_LO  = 2'd1;
  localparam logic [1:0] IDX_HI  = 2'd2;

  typedef enum logic [1:0] {
    WAIT_CMD = IDX_CMD,
    WAIT_LO  = IDX_LO,
    WAIT_HI  = IDX_HI
  } frm_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver with double-flop input sync.
// Pulses rdy on a good stop bit, frm_err on a bad one.
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       rdy,
  output logic [7:0] rx_data,
  output logic       frm_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_d;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;

  assign rx_data = r_sh;

  // Synchronizer plus one delay stage for edge detect; preset high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  // Bit timing: mid-start after half a bit, then one bit apart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_rx_d && !r_rx_s2) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            r_bit <= '0;
            if (r_rx_s2) r_state <= S_IDLE;
            else         r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt <= '0;
            r_sh  <= {r_rx_s2, r_sh[7:1]};
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            if (r_rx_s2) rdy     <= 1'b1;
            else         frm_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_wrapper.sv
// Assembles three UART bytes into a cmd/data command.
// Outputs hold until the next frame completes.
module uart_wrapper
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int GAP_TMO  = 1 << 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data
);

  localparam int GW = $clog2(GAP_TMO + 1);
  localparam logic [GW-1:0] GAP_M1 = GW'(GAP_TMO - 1);

  logic          w_rdy;
  logic          w_frm_err;
  logic [7:0]    w_rx_data;
  logic          w_done;
  logic          w_new;
  frm_state_t    r_state;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_sh_cmd;
  logic [7:0]    r_sh_lo;

  uart_rx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .rdy     (w_rdy),
    .rx_data (w_rx_data),
    .frm_err (w_frm_err)
  );

  assign w_done = w_rdy && (r_state == WAIT_HI);
  assign w_new  = w_rdy && (r_state == WAIT_CMD);

  // Frame assembly, inter-byte gap timeout, framing-error recovery
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= WAIT_CMD;
      r_gap    <= '0;
      r_sh_cmd <= '0;
      r_sh_lo  <= '0;
    end else if (w_frm_err) begin
      r_state <= WAIT_CMD;
      r_gap   <= '0;
    end else if (w_rdy) begin
      r_gap <= '0;
      unique case (r_state)
        WAIT_CMD: begin
          r_sh_cmd <= w_rx_data;
          r_state  <= WAIT_LO;
        end
        WAIT_LO: begin
          r_sh_lo <= w_rx_data;
          r_state <= WAIT_HI;
        end
        WAIT_HI: r_state <= WAIT_CMD;
        default: r_state <= WAIT_CMD;
      endcase
    end else if (r_state == WAIT_CMD) begin
      r_gap <= '0;
    end else if (r_gap == GAP_M1) begin
      r_state <= WAIT_CMD;
      r_gap   <= '0;
    end else begin
      r_gap <= r_gap + GW'(1);
    end
  end

  // Publish on frame completion; completion beats any clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy <= 1'b0;
      cmd     <= '0;
      data    <= '0;
    end else if (w_done) begin
      cmd_rdy <= 1'b1;
      cmd     <= r_sh_cmd;
      data    <= {w_rx_data, r_sh_lo};
    end else if (w_new || clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_wrapper.sv
// Directed bench for uart_wrapper.
// Fast timing: BAUD_DIV=16, GAP_TMO=512.
module tb_uart_wrapper;
  import cmd_pkg::*;

  localparam int BD  = 16;
  localparam int GAP = 512;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;

  int n_vec;
  int n_err;

  uart_wrapper #(
    .BAUD_DIV(BD),
    .GAP_TMO (GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .data        (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (cmd_rdy !== 1'b0 || cmd !== 8'h00 || data !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_outs got %b/%h/%h exp 0/00/0000",
               cmd_rdy, cmd, data);
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_vec++;
    if (cmd_rdy !== 1'b0 || dut.u_rx.r_state !== 2'd0) begin
      n_err++;
      $display("FAIL rst_release got rdy=%b rx=%0d exp 0/0",
               cmd_rdy, dut.u_rx.r_state);
    end
  endtask

  task automatic test_basic();
    send_byte(8'h02, 1'b1);
    send_byte(8'h34, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_partial got %b exp 0", cmd_rdy);
    end
    send_byte(8'h12, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h02 || data !== 16'h1234) begin
      n_err++;
      $display("FAIL basic_frame got %b/%h/%h exp 1/02/1234",
               cmd_rdy, cmd, data);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    n_vec++;
    if (cmd_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_clr got %b exp 0", cmd_rdy);
    end
    clear_rdy();
    n_vec++;
    if (cmd_rdy !== 1'b0 || cmd !== 8'h02) begin
      n_err++;
      $display("FAIL basic_idle_clr got %b/%h exp 0/02",
               cmd_rdy, cmd);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h05, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h05 || data !== 16'h01FF) begin
      n_err++;
      $display("FAIL b2b_first got %b/%h/%h exp 1/05/01ff",
               cmd_rdy, cmd, data);
    end
    send_byte(8'h03, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b0 || cmd !== 8'h05 || data !== 16'h01FF) begin
      n_err++;
      $display("FAIL b2b_stale got %b/%h/%h exp 0/05/01ff",
               cmd_rdy, cmd, data);
    end
    send_byte(8'h00, 1'b1);
    send_byte(8'h80, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h03 || data !== 16'h8000) begin
      n_err++;
      $display("FAIL b2b_second got %b/%h/%h exp 1/03/8000",
               cmd_rdy, cmd, data);
    end
  endtask

  task automatic test_gap_timeout();
    clear_rdy();
    send_byte(8'h02, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (GAP + 100) @(negedge clk);
    n_vec++;
    if (dut.r_state !== WAIT_CMD) begin
      n_err++;
      $display("FAIL gap_state got %0d exp 0", dut.r_state);
    end
    send_byte(8'h04, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL gap_no_frame got %b exp 0", cmd_rdy);
    end
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h04 || data !== 16'h0020) begin
      n_err++;
      $display("FAIL gap_frame got %b/%h/%h exp 1/04/0020",
               cmd_rdy, cmd, data);
    end
  endtask

  task automatic test_frame_err();
    clear_rdy();
    send_byte(8'h07, 1'b1);
    send_byte(8'h55, 1'b0);
    n_vec++;
    if (cmd_rdy !== 1'b0 || dut.r_state !== WAIT_CMD) begin
      n_err++;
      $display("FAIL ferr_drop got rdy=%b st=%0d exp 0/0",
               cmd_rdy, dut.r_state);
    end
    send_byte(8'h06, 1'b1);
    send_byte(8'h00, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_early got %b exp 0", cmd_rdy);
    end
    send_byte(8'h00, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h06 || data !== 16'h0000) begin
      n_err++;
      $display("FAIL ferr_frame got %b/%h/%h exp 1/06/0000",
               cmd_rdy, cmd, data);
    end
  endtask

  task automatic test_set_wins();
    logic seen;
    seen = 1'b0;
    clear_rdy();
    send_byte(8'h09, 1'b1);
    send_byte(8'h11, 1'b1);
    clr_cmd_rdy = 1'b1;
    fork
      send_byte(8'h22, 1'b1);
      begin
        for (int i = 0; i < 12 * BD; i++) begin
          @(negedge clk);
          if (!seen && cmd_rdy === 1'b1) begin
            clr_cmd_rdy = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    clr_cmd_rdy = 1'b0;
    n_vec++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL setwin_rise got %b exp 1", seen);
    end
    n_vec++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h09 || data !== 16'h2211) begin
      n_err++;
      $display("FAIL setwin_frame got %b/%h/%h exp 1/09/2211",
               cmd_rdy, cmd, data);
    end
  endtask

  task automatic test_mid_reset();
    send_byte(8'h0A, 1'b1);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
    repeat (BD) @(negedge clk);
    RX = 1'b0;
    repeat (BD + 5) @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cmd_rdy !== 1'b0 || cmd !== 8'h00 || data !== 16'h0000) begin
      n_err++;
      $display("FAIL mrst_outs got %b/%h/%h exp 0/00/0000",
               cmd_rdy, cmd, data);
    end
    n_vec++;
    if (dut.r_state !== WAIT_CMD || dut.u_rx.r_state !== 2'd0) begin
      n_err++;
      $display("FAIL mrst_state got %0d/%0d exp 0/0",
               dut.r_state, dut.u_rx.r_state);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL mrst_early got %b exp 0", cmd_rdy);
    end
    send_byte(8'h00, 1'b1);
    n_vec++;
    if (cmd_rdy !== 1'b1 || cmd !== 8'h08 || data !== 16'h0000) begin
      n_err++;
      $display("FAIL mrst_frame got %b/%h/%h exp 1/08/0000",
               cmd_rdy, cmd, data);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_gap_timeout();
    test_frame_err();
    test_set_wins();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
